// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and direction codes for the
// register file burst sequencer.
package regfile_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_HOLD,
        ST_WR_ACCEPT,
        ST_DONE
    } state_t;

    localparam logic DIR_SAVE    = 1'b0;
    localparam logic DIR_RESTORE = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] XZR_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

endpackage

// File: rtl/burst_addr_counter.sv
// Current register address and remaining-word count for one burst;
// the address wraps modulo NUM_REGS and the count is clamped at load.
module burst_addr_counter #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] first_reg,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] cur,
    output logic                  last
);

    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    logic [CNT_WIDTH-1:0]  remaining;
    logic [CNT_WIDTH-1:0]  count_clamped;
    logic [ADDR_WIDTH-1:0] cur_next;

    assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;
    assign cur_next      = (cur == TOP_ADDR) ? '0 : cur + 1'b1;
    // The word being transferred now is the final one of the burst.
    assign last          = (remaining == CNT_WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= '0;
            remaining <= '0;
        end else if (load) begin
            cur       <= first_reg;
            remaining <= count_clamped;
        end else if (step) begin
            cur       <= cur_next;
            remaining <= remaining - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_burst_sequencer.sv
// Save/restore burst engine between the register file and a word stream.
// Optional SKIP_XZR_EN makes the top register behave as a zero register.
module regfile_burst_sequencer
    import regfile_pkg::state_t, regfile_pkg::ST_IDLE, regfile_pkg::ST_RD_ISSUE,
           regfile_pkg::ST_RD_HOLD, regfile_pkg::ST_WR_ACCEPT, regfile_pkg::ST_DONE,
           regfile_pkg::DIR_RESTORE;
#(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dir,
    input  logic [ADDR_WIDTH-1:0] first_reg,
    input  logic [ADDR_WIDTH:0]   reg_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_reg_address_1,
    input  logic [DATA_WIDTH-1:0] reg_out_1,
    output logic [ADDR_WIDTH-1:0] write_reg_address,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  reg_write,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur;
    logic                  last;
    logic                  load;
    logic                  step;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  is_xzr;

    // A start during the done pulse lands in IDLE but must not launch.
    assign load    = (state == ST_IDLE) && start && !done;
    assign wr_fire = in_valid && in_ready;
    assign rd_fire = (state == ST_RD_HOLD) && out_valid && out_ready;
    assign step    = wr_fire || rd_fire;

`ifdef SKIP_XZR_EN
    localparam logic [ADDR_WIDTH-1:0] XZR = ADDR_WIDTH'(NUM_REGS - 1);
    assign is_xzr = (cur == XZR);
`else
    assign is_xzr = 1'b0;
`endif

    assign read_reg_address_1 = cur;
    assign write_reg_address  = cur;
    assign reg_write          = wr_fire && !is_xzr;
    assign data               = in_ready ? in_data : '0;

    burst_addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .first_reg (first_reg),
        .count     (reg_count),
        .cur       (cur),
        .last      (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            out_data  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (load) begin
                        busy <= 1'b1;
                        if (reg_count == '0) begin
                            state <= ST_DONE;
                        end else if (dir == DIR_RESTORE) begin
                            state    <= ST_WR_ACCEPT;
                            in_ready <= 1'b1;
                        end else begin
                            state <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    out_data  <= is_xzr ? '0 : reg_out_1;
                    out_valid <= 1'b1;
                    state     <= ST_RD_HOLD;
                end
                ST_RD_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= last ? ST_DONE : ST_RD_ISSUE;
                    end
                end
                ST_WR_ACCEPT: begin
                    if (in_valid && last) begin
                        in_ready <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_burst_sequencer.sv
// Randomised bench for regfile_burst_sequencer against an array/queue
// model of the register file and the expected stream contents.
module tb_regfile_burst_sequencer;

`ifdef SKIP_XZR_EN
    localparam bit XZR_EN = 1'b1;
`else
    localparam bit XZR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        dir;
    logic [4:0]  first_reg;
    logic [5:0]  reg_count;
    logic        busy;
    logic        done;
    logic [4:0]  read_reg_address_1;
    logic [63:0] reg_out_1;
    logic [4:0]  write_reg_address;
    logic [63:0] data;
    logic        reg_write;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;

    logic [63:0] rf [32];
    logic [63:0] seed_vals [32];
    logic [63:0] mdl [32];
    logic        tb_init;
    logic [63:0] stim_q [$];
    logic [63:0] got_q [$];
    int          n_checks;
    int          n_fail;

    regfile_burst_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .dir                (dir),
        .first_reg          (first_reg),
        .reg_count          (reg_count),
        .busy               (busy),
        .done               (done),
        .read_reg_address_1 (read_reg_address_1),
        .reg_out_1          (reg_out_1),
        .write_reg_address  (write_reg_address),
        .data               (data),
        .reg_write          (reg_write),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign reg_out_1 = rf[read_reg_address_1];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= seed_vals[i];
        end else if (reg_write) begin
            rf[write_reg_address] <= data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] save_word(input int addr);
        return (XZR_EN && addr == 31) ? 64'd0 : mdl[addr];
    endfunction

    function automatic logic pick(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc / 3) % 2) == 0;
        return $urandom_range(0, 2) != 0;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) chk(tag, rf[i], mdl[i]);
    endtask

    // One burst; mode 0 = handshake partner always ready, 1 = toggles
    // every 3 cycles, 2 = random with stray starts while busy.
    task automatic run_burst(input logic d, input int first, input int cnt,
                             input int mode);
        int n;
        int cyc;
        int hs;
        int last_hs;
        int done_cyc;
        int wi;
        int addr;
        int wr_bad;
        int ov_bad;
        int busy_bad;
        int stab_bad;
        logic v;
        logic r;
        logic exp_we;
        logic held_v;
        logic [63:0] held;
        logic [63:0] words [$];
        logic [63:0] exp_q [$];
        n = (cnt > 32) ? 32 : cnt;
        cyc = 0; hs = 0; last_hs = 0; done_cyc = -1; wi = 0;
        wr_bad = 0; ov_bad = 0; busy_bad = 0; stab_bad = 0;
        held_v = 1'b0; held = '0;
        got_q.delete();
        for (int i = 0; i < n; i++) begin
            if (stim_q.size() > 0) words.push_back(stim_q.pop_front());
            else words.push_back({$urandom, $urandom});
            exp_q.push_back(save_word((first + i) % 32));
        end
        @(negedge clk);
        start = 1'b1; dir = d;
        first_reg = 5'(first); reg_count = 6'(cnt);
        out_ready = 1'b0; in_valid = 1'b0;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (mode == 2) begin
                start = ($urandom_range(0, 3) == 0);
                first_reg = 5'($urandom);
                reg_count = 6'($urandom_range(1, 40));
                dir = ~d;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!busy) busy_bad++;
            if (d == 1'b0) begin
                if (reg_write) wr_bad++;
                if (held_v && !(out_valid && out_data == held)) stab_bad++;
                r = pick(mode, cyc);
                out_ready = r;
                if (out_valid && r) begin
                    got_q.push_back(out_data);
                    hs++;
                    last_hs = cyc;
                    held_v = 1'b0;
                end else if (out_valid) begin
                    held_v = 1'b1;
                    held = out_data;
                end else begin
                    held_v = 1'b0;
                end
            end else begin
                if (out_valid) ov_bad++;
                v = pick(mode, cyc);
                in_valid = v;
                in_data = (wi < n) ? words[wi] : {$urandom, $urandom};
                addr = (first + wi) % 32;
                #1;
                exp_we = v && (wi < n) && !(XZR_EN && addr == 31);
                if (reg_write !== exp_we) wr_bad++;
                if (exp_we && (write_reg_address != 5'(addr) ||
                               data != words[wi])) wr_bad++;
                if (v && in_ready) begin
                    if (!(XZR_EN && addr == 31)) mdl[addr] = words[wi];
                    wi++;
                    hs++;
                    last_hs = cyc;
                end
            end
        end
        chk("done_seen", done_cyc > 0, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        start = 1'b1; dir = d; first_reg = 5'(first); reg_count = 6'd3;
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 1'b0);
        chk("start_on_done_ignored", busy, 1'b0);
        chk("handshakes", hs, n);
        chk("done_latency", done_cyc - last_hs, 2);
        chk("busy_during_burst", busy_bad, 0);
        chk("reg_write_pattern", wr_bad, 0);
        if (d == 1'b0) begin
            chk("out_stable", stab_bad, 0);
            for (int i = 0; i < n && i < got_q.size(); i++)
                chk("save_word", got_q[i], exp_q[i]);
        end else begin
            chk("no_out_valid", ov_bad, 0);
        end
    endtask

    initial begin
        int bad;
        logic [63:0] w0;
        logic [63:0] w1;
        logic [63:0] w2;
        n_checks = 0; n_fail = 0;
        reset = 1'b1; tb_init = 1'b1;
        start = 1'b0; dir = 1'b0; first_reg = '0; reg_count = '0;
        out_ready = 1'b0; in_data = '0; in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            seed_vals[i] = {$urandom, $urandom};
            mdl[i] = seed_vals[i];
        end
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_raddr", read_reg_address_1, 5'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; tb_init = 1'b0;

        stim_q.push_back(64'd43);
        stim_q.push_back(64'd3);
        run_burst(1'b1, 9, 2, 0);
        chk("rf9_is_43", rf[9], 64'd43);
        chk("rf10_is_3", rf[10], 64'd3);
        run_burst(1'b0, 9, 2, 0);
        chk("save_first_43", got_q.size() > 0 ? got_q[0] : '1, 64'd43);
        chk("save_second_3", got_q.size() > 1 ? got_q[1] : '1, 64'd3);

        run_burst(1'b0, $urandom_range(0, 31), 7, 1);
        run_burst(1'b1, $urandom_range(0, 31), 6, 1);

        for (int i = 1; i <= 4; i++) stim_q.push_back(64'(i));
        run_burst(1'b1, 30, 4, 0);
        chk("wrap_rf30", rf[30], 64'd1);
        chk("wrap_rf31", rf[31], XZR_EN ? mdl[31] : 64'd2);
        chk("wrap_rf0", rf[0], 64'd3);
        chk("wrap_rf1", rf[1], 64'd4);
        run_burst(1'b0, 30, 4, 0);
        chk("wrap_save31", got_q.size() > 1 ? got_q[1] : '1,
            XZR_EN ? 64'd0 : 64'd2);
        check_regs("regs_after_wrap");

        run_burst(1'b0, 3, 0, 0);
        run_burst(1'b1, 3, 0, 2);
        run_burst(1'b1, 17, 40, 2);
        run_burst(1'b0, 17, 40, 2);
        check_regs("regs_after_count40");

        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        w2 = {$urandom, $urandom};
        @(negedge clk);
        start = 1'b1; dir = 1'b1; first_reg = 5'd5; reg_count = 6'd3;
        in_valid = 1'b1; in_data = w0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        mdl[5] = w0;
        in_data = w1;
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", in_ready, 1'b0);
        chk("abort_reg_write", reg_write, 1'b0);
        chk("abort_waddr", write_reg_address, 5'd0);
        chk("abort_data", data, 64'd0);
        chk("abort_done", done, 1'b0);
        bad = 0;
        @(negedge clk);
        in_data = w2;
        if (done) bad++;
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        chk("abort_no_done", bad, 0);
        check_regs("regs_after_abort");
        run_burst(1'b1, 5, 3, 0);
        run_burst(1'b0, 4, 5, 1);

        for (int k = 0; k < 8; k++) begin
            run_burst(1'($urandom), $urandom_range(0, 31),
                      $urandom_range(0, 40), $urandom_range(0, 2));
        end
        check_regs("regs_final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
